ram_axi_slave: RTL and testbench
================================

// Module: ram_axi_slave
// PURPOSE
//  AXI4 slave front-end for the simulation RAM model (DPI RAM controller port). Converts AXI4 bursts from
//  the core/xbar into per-beat RAM port accesses: raddr/rflag toward the model, rdata back, waddr/wdata/wmask/wen.
//  Read and write channels are independent FSMs and may run concurrently (RAM port has separate rd/wr paths).
// PARAMETERS
//  ID_W    4   AXI ID width
//  ADDR_W  32  AXI address width; zero-extended to 64 on RAM port
// PORTS
//  clock            in   1       clock; all state updates on posedge
//  resetn           in   1       synchronous reset, active-low
//  awid/awaddr      in   ID_W/ADDR_W  write-address ID, byte address
//  awlen/awsize/awburst in 8/3/2 beats-1, log2 bytes/beat (0..3), FIXED=0 INCR=1 WRAP=2
//  awvalid/awready  in/out 1     AW handshake
//  wdata/wstrb/wlast in  64/8/1  write beat data, byte strobes, last flag
//  wvalid/wready    in/out 1     W handshake
//  bid/bresp        out  ID_W/2  write response ID, OKAY=00 SLVERR=10
//  bvalid/bready    out/in 1     B handshake
//  arid/araddr/arlen/arsize/arburst in ID_W/ADDR_W/8/3/2  as AW fields
//  arvalid/arready  in/out 1     AR handshake
//  rid/rdata/rresp/rlast out ID_W/64/2/1  read beat
//  rvalid/rready    out/in 1     R handshake
//  ram_raddr        out  64      read address to RAM model
//  ram_rdata        in   64      read data, combinational from ram_raddr (same cycle)
//  ram_rflag        out  1       read-burst-start marker (difftest peripheral skip)
//  ram_waddr/ram_wdata out 64/64 write address, data
//  ram_wmask        out  64      wstrb expanded: bit 8i+j = wstrb[i]
//  ram_wen          out  1       write strobe; exactly one RAM write per cycle it is high
// BEHAVIOUR
//  Reset (resetn=0 at posedge): both FSMs -> IDLE; awready=arready=1, wready=bvalid=rvalid=0,
//   ram_wen=ram_rflag=0, ram_raddr=ram_waddr=0, beat counters 0. ram_wen also forced 0 combinationally while resetn=0.
//   Reset mid-burst abandons it; no B/R for the aborted burst.
//  Read FSM R_IDLE -> R_DATA on arvalid&arready: latch id,addr,len,size,burst; cnt=0; arready=0 in R_DATA.
//   R_DATA: ram_raddr=cur addr; rdata=ram_rdata (zero added latency); rvalid=1; rlast=(cnt==len);
//   ram_rflag=1 only in first R_DATA cycle of each burst. Outputs held stable while rready=0.
//   On rvalid&rready: cnt++, advance addr; if rlast -> R_IDLE (arready=1 next cycle). AR->first R = 1 cycle.
//  Write FSM W_IDLE -(AW hs)-> W_DATA -(last accepted beat)-> W_RESP -(bvalid&bready)-> W_IDLE.
//   W_DATA: wready=1; ram_wen=wvalid; ram_waddr=cur addr; ram_wdata=wdata; ram_wmask=expand(wstrb).
//   On wvalid&wready: cnt++, advance addr. Burst ends on wlast OR cnt==awlen, whichever first;
//   bresp=SLVERR if wlast and (cnt==awlen) disagree, else OKAY. W_RESP: bvalid=1, bid=awid, held till bready.
//  Address advance: FIXED: unchanged; INCR: addr += 1<<size (64-bit wrap permitted, no 4KB check);
//   WRAP: addressed as INCR, every beat's rresp/burst bresp=SLVERR. size>3: treated as 3, SLVERR.
//  Unaligned addr passed through unmodified; RAM model handles alignment. awlen=0/arlen=0: single beat.
//  Simultaneous AR and AW handshakes in one cycle both accepted; same-cycle rd/wr to same address:
//   read returns pre-write data (RAM model ordering), not checked by this block.
// TESTING
//  T1 reset: hold resetn=0 3 cycles mid-burst -> awready=arready=1, rvalid=bvalid=ram_wen=0, no stray B/R.
//  T2 read INCR: araddr=0x8000_0000 arlen=3 arsize=3 -> ram_raddr 0x80000000,08,10,18; rlast on beat 3;
//   ram_rflag high exactly 1 cycle; rready toggled 0/1 -> data stable, 4 beats total.
//  T3 write: awaddr=0x8000_0100 awlen=1 wstrb=0x0F then 0xF0 -> ram_wmask 0x00000000FFFFFFFF then
//   0xFFFFFFFF00000000, ram_wen 2 cycles, bresp=OKAY, bid=awid.
//  T4 early wlast: awlen=3, wlast on beat 1 -> 2 RAM writes, bresp=SLVERR; missing wlast at beat 3 -> SLVERR.
//  T5 concurrent: AR and AW same cycle, arburst=FIXED len=2 -> ram_raddr constant 3 beats; write completes
//   independently; rid/bid match respective IDs.
//  T6 WRAP burst len=1 -> INCR addressing, both rresp=SLVERR.

Source files
------------

// File: rtl/ram_axi_slave.sv
// AXI4 slave front-end for the simulation RAM model.
// Splits AXI4 read and write bursts into per-beat RAM port accesses.
// The read and write paths are independent and may run at the same time.
module ram_axi_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  // write address channel
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // read address channel
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [ID_W-1:0]   rid,
  output logic [63:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // RAM model port
  output logic [63:0]       ram_raddr,
  input  logic [63:0]       ram_rdata,
  output logic              ram_rflag,
  output logic [63:0]       ram_waddr,
  output logic [63:0]       ram_wdata,
  output logic [63:0]       ram_wmask,
  output logic              ram_wen
);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // FIXED bursts keep the address; everything else (WRAP included) steps by the beat size
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) begin
      return addr;
    end
    return addr + (64'd1 << sz);
  endfunction

  // Sizes above 8 bytes/beat are clamped to 8 bytes and flagged as errors
  function automatic logic [1:0] clamp_size(input logic [2:0] size);
    return (size > 3'd3) ? 2'd3 : size[1:0];
  endfunction

  function automatic logic burst_error(input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_WRAP) || (size > 3'd3);
  endfunction

  // read path state
  logic [0:0]      r_state;
  logic [ID_W-1:0] r_id;
  logic [63:0]     r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic [1:0]      r_sz;
  logic [1:0]      r_burst;
  logic            r_err;
  logic            r_first;

  // write path state
  logic [1:0]      w_state;
  logic [ID_W-1:0] w_id;
  logic [63:0]     w_addr;
  logic [7:0]      w_len;
  logic [7:0]      w_cnt;
  logic [1:0]      w_sz;
  logic [1:0]      w_burst;
  logic            w_err;
  logic [1:0]      w_bresp;

  logic w_len_hit;
  assign w_len_hit = (w_cnt == w_len);

  // Read FSM: accept a burst in idle, then stream one beat per rvalid&rready
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_sz    <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_id    <= arid;
            r_addr  <= 64'(araddr);
            r_len   <= arlen;
            r_cnt   <= '0;
            r_sz    <= clamp_size(arsize);
            r_burst <= arburst;
            r_err   <= burst_error(arsize, arburst);
            r_first <= 1'b1;
            r_state <= R_DATA;
          end
        end
        default: begin
          r_first <= 1'b0;
          if (rready) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= next_addr(r_addr, r_sz, r_burst);
            if (r_cnt == r_len) begin
              r_state <= R_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Write FSM: accept a burst, write each beat, then hold the response until taken
  always_ff @(posedge clock) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_sz    <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_bresp <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid) begin
            w_id    <= awid;
            w_addr  <= 64'(awaddr);
            w_len   <= awlen;
            w_cnt   <= '0;
            w_sz    <= clamp_size(awsize);
            w_burst <= awburst;
            w_err   <= burst_error(awsize, awburst);
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= next_addr(w_addr, w_sz, w_burst);
            if (wlast || w_len_hit) begin
              w_bresp <= (w_err || (wlast != w_len_hit)) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Byte strobes widened to a bit mask for the RAM model
  always_comb begin
    ram_wmask = '0;
    for (int i = 0; i < 8; i++) begin
      ram_wmask[8*i +: 8] = {8{wstrb[i]}};
    end
  end

  assign arready   = (r_state == R_IDLE);
  assign rvalid    = (r_state == R_DATA);
  assign rid       = r_id;
  assign rdata     = ram_rdata;
  assign rlast     = (r_cnt == r_len);
  assign rresp     = r_err ? RESP_SLVERR : RESP_OKAY;
  assign ram_raddr = r_addr;
  assign ram_rflag = (r_state == R_DATA) && r_first;

  assign awready   = (w_state == W_IDLE);
  assign wready    = (w_state == W_DATA);
  assign bvalid    = (w_state == W_RESP);
  assign bid       = w_id;
  assign bresp     = w_bresp;
  assign ram_waddr = w_addr;
  assign ram_wdata = wdata;
  assign ram_wen   = resetn && (w_state == W_DATA) && wvalid;

endmodule

// File: tb/tb_ram_axi_slave.sv
// Scoreboard testbench for ram_axi_slave.
// Stimulus tasks push expected beats/responses; a negedge monitor pops and compares.
module tb_ram_axi_slave;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;

  logic              clock;
  logic              resetn;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [63:0]       ram_raddr;
  logic [63:0]       ram_rdata;
  logic              ram_rflag;
  logic [63:0]       ram_waddr;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_wmask;
  logic              ram_wen;

  ram_axi_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_rflag(ram_rflag),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  typedef struct {
    logic [3:0]  id;
    logic [63:0] addr;
    logic        last;
    logic [1:0]  resp;
    logic        first;
  } rbeat_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] mask;
  } wbeat_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t     rq[$];
  wbeat_t     wq[$];
  bexp_t      bq[$];
  logic [7:0] strb_tbl[$];

  int checks = 0;
  int errors = 0;
  int rflag_seen = 0;
  int rflag_exp = 0;
  int rready_mode = 1;

  rbeat_t mon_r;
  wbeat_t mon_w;
  bexp_t  mon_b;

  // Fake RAM contents: a fixed function of the address, same cycle
  function automatic logic [63:0] rd_model(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEADBEEF, a[31:0] + 32'h13579BDF} ^ {32'h0, a[63:32]};
  endfunction

  // Address of beat k of a burst, straight from the burst rules
  function automatic logic [63:0] beat_addr(input logic [31:0] base, input logic [2:0] size,
                                            input logic [1:0] burst, input int k);
    int sz;
    sz = (size > 3'd3) ? 3 : int'(size);
    if (burst == 2'd0) return 64'(base);
    return 64'(base) + 64'(k) * (64'd1 << sz);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign ram_rdata = rd_model(ram_raddr);

  // Random backpressure on R and B
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      rready = (rready_mode == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: compare every presented R beat, RAM write and B response against the queues
  initial begin
    forever begin
      @(negedge clock);
      if (ram_rflag) begin
        rflag_seen++;
        checkOutput("rflag_on_first_beat",
                    {63'd0, rvalid && (rq.size() > 0) && rq[0].first}, 64'd1);
      end
      if (rvalid) begin
        if (rq.size() == 0) begin
          if (rready) failNow("stray_r_beat");
        end else begin
          mon_r = rq[0];
          checkOutput("ram_raddr", ram_raddr, mon_r.addr);
          checkOutput("rdata", rdata, rd_model(mon_r.addr));
          checkOutput("rid", 64'(rid), 64'(mon_r.id));
          checkOutput("rlast", 64'(rlast), 64'(mon_r.last));
          checkOutput("rresp", 64'(rresp), 64'(mon_r.resp));
          if (rready) void'(rq.pop_front());
        end
      end
      if (ram_wen) begin
        if (wq.size() == 0) begin
          failNow("stray_ram_write");
        end else begin
          mon_w = wq.pop_front();
          checkOutput("ram_waddr", ram_waddr, mon_w.addr);
          checkOutput("ram_wdata", ram_wdata, mon_w.data);
          checkOutput("ram_wmask", ram_wmask, mon_w.mask);
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          failNow("stray_b_response");
        end else begin
          mon_b = bq.pop_front();
          checkOutput("bid", 64'(bid), 64'(mon_b.id));
          checkOutput("bresp", 64'(bresp), 64'(mon_b.resp));
        end
      end
    end
  end

  // Watchdog so a hung handshake can never stall the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic doRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] resp;
    int n;
    resp = ((burst == 2'd2) || (size > 3'd3)) ? 2'b10 : 2'b00;
    for (int k = 0; k <= int'(len); k++) begin
      rq.push_back('{id, beat_addr(addr, size, burst, k), (k == int'(len)), resp, (k == 0)});
    end
    rflag_exp++;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clock);
      if (arready) break;
      if (++n > 200) begin failNow("ar_handshake"); break; end
    end
    @(posedge clock);
    #1;
    arvalid = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clock);
      if (rvalid && rready && rlast) break;
      if (++n > 3000) begin failNow("read_burst_end"); break; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doWrite(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int wlast_at);
    int beats;
    int n;
    logic err;
    logic [7:0] s;
    logic [63:0] d;
    logic [63:0] m;
    err   = (burst == 2'd2) || (size > 3'd3) || (wlast_at != int'(len));
    beats = (wlast_at <= int'(len)) ? wlast_at + 1 : int'(len) + 1;
    bq.push_back('{id, err ? 2'b10 : 2'b00});
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clock);
      if (awready) break;
      if (++n > 200) begin failNow("aw_handshake"); break; end
    end
    @(posedge clock);
    #1;
    awvalid = 1'b0;
    for (int k = 0; k < beats; k++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clock);
        #1;
      end
      s = (strb_tbl.size() > 0) ? strb_tbl.pop_front() : 8'($urandom);
      d = {$urandom, $urandom};
      m = '0;
      for (int i = 0; i < 8; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
      wq.push_back('{beat_addr(addr, size, burst, k), d, m});
      wdata = d; wstrb = s; wlast = (k == wlast_at); wvalid = 1'b1;
      n = 0;
      while (1) begin
        @(negedge clock);
        if (wready) break;
        if (++n > 200) begin failNow("w_handshake"); break; end
      end
      @(posedge clock);
      #1;
      wvalid = 1'b0;
      wlast  = 1'b0;
    end
    n = 0;
    while (1) begin
      @(negedge clock);
      if (bvalid && bready) break;
      if (++n > 500) begin failNow("b_handshake"); break; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_awready"}, 64'(awready), 64'd1);
    checkOutput({tag, "_arready"}, 64'(arready), 64'd1);
    checkOutput({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    checkOutput({tag, "_bvalid"}, 64'(bvalid), 64'd0);
    checkOutput({tag, "_ram_wen"}, 64'(ram_wen), 64'd0);
    checkOutput({tag, "_ram_raddr"}, ram_raddr, 64'd0);
    checkOutput({tag, "_ram_waddr"}, ram_waddr, 64'd0);
  endtask

  // Abandon a read and a write burst with reset and confirm no response leaks out
  task automatic resetMidBurst();
    rready_mode = 0;
    rready = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      rq.push_back('{4'h9, 64'h8000_0400 + 64'(k) * 64'd8, (k == 3), 2'b00, (k == 0)});
    end
    rflag_exp++;
    arid = 4'h9; araddr = 32'h8000_0400; arlen = 8'd3; arsize = 3'd3; arburst = 2'd1;
    awid = 4'h6; awaddr = 32'h8000_0500; awlen = 8'd3; awsize = 3'd3; awburst = 2'd1;
    arvalid = 1'b1;
    awvalid = 1'b1;
    @(negedge clock);
    checkOutput("t1_pre_arready", 64'(arready), 64'd1);
    @(posedge clock);
    #1;
    arvalid = 1'b0;
    awvalid = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    wvalid = 1'b1;
    wdata  = 64'h1111_2222_3333_4444;
    wstrb  = 8'hFF;
    @(negedge clock);
    checkOutput("t1_wen_gated_in_reset", 64'(ram_wen), 64'd0);
    @(posedge clock);
    #1;
    rq.delete();
    wq.delete();
    bq.delete();
    repeat (2) begin
      @(negedge clock);
      checkResetState("t1");
      @(posedge clock);
      #1;
    end
    resetn = 1'b1;
    wvalid = 1'b0;
    rready_mode = 1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("t1_no_stray_b", 64'(bvalid), 64'd0);
      checkOutput("t1_no_stray_r", 64'(rvalid), 64'd0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus();
    logic [3:0]  id_r, id_w;
    logic [31:0] a_r, a_w;
    logic [7:0]  l_r, l_w;
    logic [2:0]  s_r, s_w;
    logic [1:0]  b_r, b_w;
    int          wl;

    // T2: INCR read of four doublewords with random rready
    doRead(4'h3, 32'h8000_0000, 8'd3, 3'd3, 2'd1);

    // T3: two-beat write with complementary strobes
    strb_tbl.push_back(8'h0F);
    strb_tbl.push_back(8'hF0);
    doWrite(4'h5, 32'h8000_0100, 8'd1, 3'd3, 2'd1, 1);

    // T4: early wlast, then missing wlast
    doWrite(4'h7, 32'h8000_0200, 8'd3, 3'd3, 2'd1, 1);
    doWrite(4'h8, 32'h8000_0300, 8'd3, 3'd2, 2'd1, 4);

    // T5: concurrent FIXED read and INCR write
    fork
      doRead(4'hA, 32'h8000_1000, 8'd2, 3'd3, 2'd0);
      doWrite(4'hB, 32'h8000_2000, 8'd2, 3'd1, 2'd1, 2);
    join

    // T6: WRAP treated as INCR with SLVERR, and an oversized beat
    doRead(4'hC, 32'h8000_3000, 8'd1, 3'd3, 2'd2);
    doWrite(4'hD, 32'h8000_3100, 8'd1, 3'd2, 2'd2, 1);
    doRead(4'h2, 32'h8000_3204, 8'd0, 3'd5, 2'd1);

    // Random concurrent traffic
    for (int i = 0; i < 12; i++) begin
      id_r = 4'($urandom); id_w = 4'($urandom);
      a_r  = $urandom;     a_w  = $urandom;
      l_r  = 8'($urandom_range(0, 7));
      l_w  = 8'($urandom_range(0, 7));
      s_r  = 3'($urandom_range(0, 4));
      s_w  = 3'($urandom_range(0, 4));
      b_r  = 2'($urandom_range(0, 2));
      b_w  = 2'($urandom_range(0, 2));
      wl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(l_w) + 1) : int'(l_w);
      fork
        doRead(id_r, a_r, l_r, s_r, b_r);
        doWrite(id_w, a_w, l_w, s_w, b_w, wl);
      join
    end

    // T1: reset in the middle of bursts, then confirm normal operation resumes
    resetMidBurst();
    fork
      doRead(4'h1, 32'h8000_4000, 8'd2, 3'd3, 2'd1);
      doWrite(4'h4, 32'h8000_5000, 8'd0, 3'd3, 2'd1, 0);
    join
  endtask

  // Main sequence: reset, directed and random bursts, final bookkeeping, summary
  initial begin
    resetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    checkResetState("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;

    applyStimulus();

    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("r_queue_drained", 64'(rq.size()), 64'd0);
    checkOutput("w_queue_drained", 64'(wq.size()), 64'd0);
    checkOutput("b_queue_drained", 64'(bq.size()), 64'd0);
    checkOutput("rflag_pulse_count", 64'(rflag_seen), 64'(rflag_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
